// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and helpers for the 5-stage pipeline sequencer.
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // r0 is hardwired to zero, so it never produces a dependency.
    function automatic logic src_hit(
        input logic       use_src,
        input logic [4:0] src,
        input logic       stage_valid,
        input logic       stage_gr_we,
        input logic [4:0] stage_dest
    );
        return use_src && (src != REG_ZERO) && stage_valid && stage_gr_we
               && (stage_dest == src);
    endfunction

endpackage

// File: rtl/pipe_ctrl_fwd_sel.sv
// Per-operand bypass matcher: picks the youngest producer and flags an interlock
// when that producer's result is not yet available.
module fwd_sel
    import pipe_ctrl_pkg::*;
(
    input  logic       use_src,
    input  logic [4:0] src,
    input  logic       ex_valid,
    input  logic       ex_gr_we,
    input  logic [4:0] ex_dest,
    input  logic       ex_load,
    input  logic       ex_ready_go,
    input  logic       mem_valid,
    input  logic       mem_gr_we,
    input  logic [4:0] mem_dest,
    input  logic       mem_load,
    input  logic       mem_ready_go,
    input  logic       wb_valid,
    input  logic       wb_gr_we,
    input  logic [4:0] wb_dest,
    output logic [1:0] sel,
    output logic       stall
);

    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    always_comb begin
        hit_ex  = src_hit(use_src, src, ex_valid, ex_gr_we, ex_dest);
        hit_mem = src_hit(use_src, src, mem_valid, mem_gr_we, mem_dest);
        hit_wb  = src_hit(use_src, src, wb_valid, wb_gr_we, wb_dest);

        sel = FWD_RF;
        if (hit_ex)
            sel = FWD_EX;
        else if (hit_mem)
            sel = FWD_MEM;
        else if (hit_wb)
            sel = FWD_WB;

        stall = (hit_ex && (ex_load || !ex_ready_go))
             || (hit_mem && mem_load && !mem_ready_go);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stage valids, allowin/ready_go handshakes, bypass selects,
// load-use / multi-cycle interlocks and wrong-path fetch squashing.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_inst_valid,
    input  logic [4:0]       id_rj,
    input  logic [4:0]       id_rk,
    input  logic             id_use_rj,
    input  logic             id_use_rk,
    input  logic             id_gr_we,
    input  logic [4:0]       id_dest,
    input  logic             id_load_op,
    input  logic             id_br_taken,
    input  logic             ex_ready_go,
    input  logic             mem_ready_go,
    output logic             if_pc_en,
    output logic             id_en,
    output logic             ex_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             id_valid,
    output logic             ex_valid,
    output logic             mem_valid,
    output logic             wb_valid,
    output logic [1:0]       fwd_rj_sel,
    output logic [1:0]       fwd_rk_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic       cancel_q;
    logic       ex_gr_we, ex_load, mem_gr_we, mem_load, wb_gr_we;
    logic [4:0] ex_dest, mem_dest, wb_dest;

    logic       allowin_id, allowin_ex, allowin_mem;
    logic       id_ready_go, br_flush, fetch_drop;
    logic       to_id_valid, to_ex_valid, to_mem_valid, to_wb_valid;
    logic [1:0] rj_sel, rk_sel;
    logic       rj_stall, rk_stall;

    fwd_sel u_fwd_rj (
        .use_src(id_use_rj), .src(id_rj),
        .ex_valid(ex_valid), .ex_gr_we(ex_gr_we), .ex_dest(ex_dest),
        .ex_load(ex_load), .ex_ready_go(ex_ready_go),
        .mem_valid(mem_valid), .mem_gr_we(mem_gr_we), .mem_dest(mem_dest),
        .mem_load(mem_load), .mem_ready_go(mem_ready_go),
        .wb_valid(wb_valid), .wb_gr_we(wb_gr_we), .wb_dest(wb_dest),
        .sel(rj_sel), .stall(rj_stall)
    );

    fwd_sel u_fwd_rk (
        .use_src(id_use_rk), .src(id_rk),
        .ex_valid(ex_valid), .ex_gr_we(ex_gr_we), .ex_dest(ex_dest),
        .ex_load(ex_load), .ex_ready_go(ex_ready_go),
        .mem_valid(mem_valid), .mem_gr_we(mem_gr_we), .mem_dest(mem_dest),
        .mem_load(mem_load), .mem_ready_go(mem_ready_go),
        .wb_valid(wb_valid), .wb_gr_we(wb_gr_we), .wb_dest(wb_dest),
        .sel(rk_sel), .stall(rk_stall)
    );

    // WB always accepts, so allowin_wb folds to 1.
    assign id_ready_go  = !(rj_stall || rk_stall);
    assign allowin_mem  = !mem_valid || mem_ready_go;
    assign allowin_ex   = !ex_valid || (ex_ready_go && allowin_mem);
    assign allowin_id   = !id_valid || (id_ready_go && allowin_ex);

    assign br_flush     = id_valid && id_ready_go && id_br_taken;
    assign to_id_valid  = if_inst_valid && !cancel_q && !br_flush;
    assign to_ex_valid  = id_valid && id_ready_go;
    assign to_mem_valid = ex_valid && ex_ready_go;
    assign to_wb_valid  = mem_valid && mem_ready_go;
    assign fetch_drop   = if_inst_valid && (cancel_q || br_flush);

    always_comb begin
        if_pc_en   = 1'b1;
        id_en      = 1'b0;
        ex_en      = 1'b0;
        mem_en     = 1'b0;
        wb_en      = 1'b0;
        fwd_rj_sel = FWD_RF;
        fwd_rk_sel = FWD_RF;
        if (!reset) begin
            if_pc_en   = br_flush || (if_inst_valid && allowin_id);
            id_en      = allowin_id && to_id_valid;
            ex_en      = allowin_ex && to_ex_valid;
            mem_en     = allowin_mem && to_mem_valid;
            wb_en      = to_wb_valid;
            fwd_rj_sel = rj_sel;
            fwd_rk_sel = rk_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid  <= 1'b0;
            ex_valid  <= 1'b0;
            mem_valid <= 1'b0;
            wb_valid  <= 1'b0;
            cancel_q  <= 1'b0;
            ex_gr_we  <= 1'b0;
            ex_load   <= 1'b0;
            ex_dest   <= REG_ZERO;
            mem_gr_we <= 1'b0;
            mem_load  <= 1'b0;
            mem_dest  <= REG_ZERO;
            wb_gr_we  <= 1'b0;
            wb_dest   <= REG_ZERO;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (allowin_id)  id_valid  <= to_id_valid;
            if (allowin_ex)  ex_valid  <= to_ex_valid;
            if (allowin_mem) mem_valid <= to_mem_valid;
            wb_valid <= to_wb_valid;

            if (allowin_ex && to_ex_valid) begin
                ex_gr_we <= id_gr_we;
                ex_load  <= id_load_op;
                ex_dest  <= id_dest;
            end
            if (allowin_mem && to_mem_valid) begin
                mem_gr_we <= ex_gr_we;
                mem_load  <= ex_load;
                mem_dest  <= ex_dest;
            end
            if (to_wb_valid) begin
                wb_gr_we <= mem_gr_we;
                wb_dest  <= mem_dest;
            end

            // An outstanding wrong-path fetch is remembered and eaten when it returns.
            if (br_flush && !if_inst_valid)
                cancel_q <= 1'b1;
            else if (cancel_q && if_inst_valid)
                cancel_q <= 1'b0;

            if (id_valid && !id_ready_go) stall_cnt <= stall_cnt + 1'b1;
            if (fetch_drop)               flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: forwarding, interlocks, branch squash,
// back-pressure and reset, with hand-computed expectations.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_inst_valid;
    logic [4:0]  id_rj, id_rk, id_dest;
    logic        id_use_rj, id_use_rk, id_gr_we, id_load_op, id_br_taken;
    logic        ex_ready_go, mem_ready_go;
    logic        if_pc_en, id_en, ex_en, mem_en, wb_en;
    logic        id_valid, ex_valid, mem_valid, wb_valid;
    logic [1:0]  fwd_rj_sel, fwd_rk_sel;
    logic [31:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .if_inst_valid(if_inst_valid),
        .id_rj(id_rj), .id_rk(id_rk), .id_use_rj(id_use_rj), .id_use_rk(id_use_rk),
        .id_gr_we(id_gr_we), .id_dest(id_dest), .id_load_op(id_load_op),
        .id_br_taken(id_br_taken), .ex_ready_go(ex_ready_go), .mem_ready_go(mem_ready_go),
        .if_pc_en(if_pc_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en),
        .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .fwd_rj_sel(fwd_rj_sel), .fwd_rk_sel(fwd_rk_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_id(input logic [4:0] rj, input logic [4:0] rk,
                          input logic urj, input logic urk, input logic we,
                          input logic [4:0] dest, input logic ld, input logic br);
        id_rj = rj; id_rk = rk; id_use_rj = urj; id_use_rk = urk;
        id_gr_we = we; id_dest = dest; id_load_op = ld; id_br_taken = br;
    endtask

    initial begin
        reset = 1'b1;
        if_inst_valid = 1'b1;
        ex_ready_go = 1'b1;
        mem_ready_go = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(); cycle();
        #1;
        check("rst_if_pc_en", 32'(if_pc_en), 1);
        check("rst_id_en", 32'(id_en), 0);
        check("rst_id_valid", 32'(id_valid), 0);
        check("rst_wb_valid", 32'(wb_valid), 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        reset = 1'b0;
        if_inst_valid = 1'b0;
        cycle();

        // add r4,r1,r2 ; add r5,r4,r3 ; sub r6,r1,r4 ; or r7,r5,r4
        if_inst_valid = 1'b1; #1;
        check("t1_id_en", 32'(id_en), 1);
        cycle();
        set_id(1, 2, 1, 1, 1, 4, 0, 0); #1;
        check("t1_ex_en", 32'(ex_en), 1);
        cycle();
        set_id(4, 3, 1, 1, 1, 5, 0, 0); #1;
        check("t1_fwd_rj_ex", 32'(fwd_rj_sel), 1);
        check("t1_fwd_rk_rf", 32'(fwd_rk_sel), 0);
        cycle();
        set_id(1, 4, 1, 1, 1, 6, 0, 0); #1;
        check("t1_fwd_rj_rf", 32'(fwd_rj_sel), 0);
        check("t1_fwd_rk_mem", 32'(fwd_rk_sel), 2);
        cycle();
        set_id(5, 4, 1, 1, 1, 7, 0, 0); if_inst_valid = 1'b0; #1;
        check("t1_fwd_rj_mem", 32'(fwd_rj_sel), 2);
        check("t1_fwd_rk_wb", 32'(fwd_rk_sel), 3);
        check("t1_stall_cnt", stall_cnt, 0);
        cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        drain(5);
        check("t1_drained", 32'({id_valid, ex_valid, mem_valid, wb_valid}), 0);

        // ld.w r4 ; add r5,r4,r3  -> one interlock cycle
        if_inst_valid = 1'b1; #1; cycle();
        set_id(1, 0, 1, 0, 1, 4, 1, 0); #1; cycle();
        set_id(4, 3, 1, 1, 1, 5, 0, 0); #1;
        check("t2_fwd_rj_ex", 32'(fwd_rj_sel), 1);
        check("t2_ex_en_held", 32'(ex_en), 0);
        check("t2_id_en_held", 32'(id_en), 0);
        check("t2_if_pc_en_held", 32'(if_pc_en), 0);
        cycle();
        if_inst_valid = 1'b0; #1;
        check("t2_stall_cnt", stall_cnt, 1);
        check("t2_id_valid", 32'(id_valid), 1);
        check("t2_ex_bubble", 32'(ex_valid), 0);
        check("t2_fwd_rj_mem", 32'(fwd_rj_sel), 2);
        check("t2_ex_en_go", 32'(ex_en), 1);
        cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        drain(5);

        // taken branch while the next fetch is still outstanding
        if_inst_valid = 1'b1; #1; cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 1); if_inst_valid = 1'b0; #1;
        check("t3_if_pc_en_flush", 32'(if_pc_en), 1);
        check("t3_ex_en_br", 32'(ex_en), 1);
        cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0); if_inst_valid = 1'b1; #1;
        check("t3_drop_id_en", 32'(id_en), 0);
        check("t3_flush_cnt_pre", flush_cnt, 0);
        cycle();
        #1;
        check("t3_flush_cnt", flush_cnt, 1);
        check("t3_id_empty", 32'(id_valid), 0);
        check("t3_target_id_en", 32'(id_en), 1);
        cycle();
        if_inst_valid = 1'b0; #1;
        check("t3_target_in_id", 32'(id_valid), 1);
        cycle();
        drain(5);

        // taken branch with the wrong-path fetch already present
        if_inst_valid = 1'b1; #1; cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 1); #1;
        check("t3b_id_en", 32'(id_en), 0);
        check("t3b_if_pc_en", 32'(if_pc_en), 1);
        cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0); if_inst_valid = 1'b0; #1;
        check("t3b_flush_cnt", flush_cnt, 2);
        check("t3b_id_empty", 32'(id_valid), 0);
        cycle();
        drain(5);

        // multi-cycle EX op with a dependent instruction waiting in ID
        if_inst_valid = 1'b1; #1; cycle();
        set_id(1, 2, 1, 1, 1, 6, 0, 0); #1; cycle();
        set_id(6, 1, 1, 1, 1, 7, 0, 0); if_inst_valid = 1'b0; ex_ready_go = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t4_id_held", 32'(id_valid), 1);
            check("t4_ex_held", 32'(ex_valid), 1);
            check("t4_mem_stable", 32'(mem_valid), 0);
            check("t4_ex_en", 32'(ex_en), 0);
            check("t4_stall_cnt", stall_cnt, 32'(1 + k));
            cycle();
        end
        ex_ready_go = 1'b1; #1;
        check("t4_stall_cnt_end", stall_cnt, 4);
        check("t4_fwd_rj_ex", 32'(fwd_rj_sel), 1);
        check("t4_ex_en_go", 32'(ex_en), 1);
        cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        drain(5);

        // four live instructions, MEM back-pressure, then reset
        if_inst_valid = 1'b1;
        drain(4);
        mem_ready_go = 1'b0; #1;
        check("t5_full", 32'({id_valid, ex_valid, mem_valid, wb_valid}), 4'b1111);
        check("t5_if_pc_en", 32'(if_pc_en), 0);
        check("t5_mem_en", 32'(mem_en), 0);
        check("t5_wb_en", 32'(wb_en), 0);
        cycle();
        #1;
        check("t5_held", 32'({id_valid, ex_valid, mem_valid, wb_valid}), 4'b1110);
        mem_ready_go = 1'b1; reset = 1'b1; #1;
        check("t5_rst_if_pc_en", 32'(if_pc_en), 1);
        check("t5_rst_ex_en", 32'(ex_en), 0);
        cycle();
        #1;
        check("t5_rst_valids", 32'({id_valid, ex_valid, mem_valid, wb_valid}), 0);
        check("t5_rst_stall_cnt", stall_cnt, 0);
        check("t5_rst_flush_cnt", flush_cnt, 0);
        reset = 1'b0; if_inst_valid = 1'b0;
        cycle();

        // ld.w r0 ; add r5,r0,r0 -> no forwarding, no stall
        if_inst_valid = 1'b1; #1; cycle();
        set_id(1, 0, 1, 0, 1, 0, 1, 0); #1; cycle();
        set_id(0, 0, 1, 1, 1, 5, 0, 0); if_inst_valid = 1'b0; #1;
        check("t6_fwd_rj_r0", 32'(fwd_rj_sel), 0);
        check("t6_fwd_rk_r0", 32'(fwd_rk_sel), 0);
        check("t6_ex_en", 32'(ex_en), 1);
        cycle();
        #1;
        check("t6_stall_cnt", stall_cnt, 0);
        check("t6_reader_in_ex", 32'(ex_valid), 1);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        drain(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
